// File: rtl/uart_ctrl_pkg.sv
// Types and constants shared by the UART controller blocks.
package uart_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    LISTEN = 2'b01,
    WRITE  = 2'b10,
    DONE   = 2'b11
  } rx_ctrl_state_t;

  localparam logic [7:0] ERR_CNT_MAX = 8'hFF;

endpackage

// File: rtl/uart_rx_timeout.sv
// Inter-byte idle counter. It flags expiry on the cycle whose increment would
// bring the count to TIMEOUT_CYCLES-1.
module uart_rx_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 2);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = en && !clr && (cnt_q == LAST);

endmodule

// File: rtl/uart_rx_control.sv
// Receive controller: buffers bytes from uart_rx and writes them to sequential
// memory addresses, tracking errors, overruns and inter-byte timeout.
module uart_rx_control
  import uart_ctrl_pkg::*;
#(
  parameter int unsigned NUM_OF_BYTES   = 4,
  parameter int unsigned ADDR_WIDTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [7:0]            uart_rx_data,
  input  logic                  uart_rx_done,
  input  logic                  uart_rx_error,
  output logic [ADDR_WIDTH-1:0] mem_write_addr,
  output logic [7:0]            mem_write_data,
  output logic                  mem_write_enable,
  output logic                  reception_done,
  output logic                  reception_timeout,
  output logic                  overrun,
  output logic [7:0]            error_count,
  output logic [ADDR_WIDTH:0]   bytes_received
);

  localparam int unsigned BW = ADDR_WIDTH + 1;
  localparam logic [BW-1:0] NUM_LAST = BW'(NUM_OF_BYTES);

  rx_ctrl_state_t        state_q, state_d;
  logic [7:0]            hold_q, hold_d;
  logic                  hold_valid_q, hold_valid_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            data_q, data_d;
  logic                  we_q, we_d;
  logic                  done_q, done_d;
  logic                  tmo_q, tmo_d;
  logic                  ovr_q, ovr_d;
  logic [7:0]            err_q, err_d;
  logic [BW-1:0]         br_q, br_d;

  logic idle_like, active, consume, tmo_clr, tmo_en, tmo_expired;

  assign idle_like = (state_q == IDLE) || (state_q == DONE);
  assign active    = (state_q == LISTEN) || (state_q == WRITE);
  assign consume   = (state_q == LISTEN) && hold_valid_q;
  assign tmo_clr   = (idle_like && start) || consume;
  assign tmo_en    = (state_q == LISTEN) && !hold_valid_q && (br_q != '0);

  uart_rx_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rstn   (rstn),
    .clr    (tmo_clr),
    .en     (tmo_en),
    .expired(tmo_expired)
  );

  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    addr_d       = addr_q;
    data_d       = data_q;
    we_d         = 1'b0;
    done_d       = done_q;
    tmo_d        = tmo_q;
    ovr_d        = ovr_q;
    err_d        = err_q;
    br_d         = br_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          br_d         = '0;
          done_d       = 1'b0;
          tmo_d        = 1'b0;
          ovr_d        = 1'b0;
          err_d        = '0;
          hold_valid_d = 1'b0;
          state_d      = LISTEN;
        end
      end
      LISTEN: begin
        if (hold_valid_q) begin
          we_d         = 1'b1;
          addr_d       = br_q[ADDR_WIDTH-1:0];
          data_d       = hold_q;
          br_d         = br_q + BW'(1);
          hold_valid_d = 1'b0;
          state_d      = WRITE;
        end else if (tmo_expired) begin
          tmo_d   = 1'b1;
          state_d = DONE;
        end
      end
      WRITE: begin
        if (br_q == NUM_LAST) begin
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          state_d = LISTEN;
        end
      end
      default: state_d = IDLE;
    endcase

    // Evaluated after the consume above so a byte landing on the consume cycle refills hold.
    if (active && uart_rx_done) begin
      if (uart_rx_error) begin
        if (err_q != ERR_CNT_MAX) err_d = err_q + 8'd1;
      end else if (hold_valid_q && !consume) begin
        ovr_d = 1'b1;
      end else begin
        hold_d       = uart_rx_data;
        hold_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      we_q         <= 1'b0;
      done_q       <= 1'b0;
      tmo_q        <= 1'b0;
      ovr_q        <= 1'b0;
      err_q        <= '0;
      br_q         <= '0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      we_q         <= we_d;
      done_q       <= done_d;
      tmo_q        <= tmo_d;
      ovr_q        <= ovr_d;
      err_q        <= err_d;
      br_q         <= br_d;
    end
  end

  assign mem_write_addr    = addr_q;
  assign mem_write_data    = data_q;
  assign mem_write_enable  = we_q;
  assign reception_done    = done_q;
  assign reception_timeout = tmo_q;
  assign overrun           = ovr_q;
  assign error_count       = err_q;
  assign bytes_received    = br_q;

endmodule
